// File: rtl/barramento_pkg.sv
// Shared types for the snooping bus sequencer.
// Holds the MSI state codes, bus op codes, FSM state encoding and the snoop reaction rule.
package barramento_pkg;

   typedef enum logic [1:0] {
      MSI_I = 2'b00,
      MSI_S = 2'b01,
      MSI_M = 2'b10
   } msi_t;

   typedef enum logic [1:0] {
      OP_NONE    = 2'b00,
      OP_RD_MISS = 2'b01,
      OP_WR_MISS = 2'b10,
      OP_INVAL   = 2'b11
   } bus_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_WB,
      ST_SNOOP,
      ST_FLUSH,
      ST_MEM,
      ST_DONE
   } state_t;

   // Reaction of a non-requesting cache to a broadcast op: {needs_flush, next_state}.
   function automatic logic [2:0] snoop_rule(input logic [1:0] cur, input logic [1:0] op);
      logic [2:0] res;
      res = {1'b0, cur};
      if (cur == MSI_M && op == OP_RD_MISS) begin
         res = {1'b1, MSI_S};
      end else if (cur == MSI_M && op == OP_WR_MISS) begin
         res = {1'b1, MSI_I};
      end else if (cur == MSI_S && (op == OP_WR_MISS || op == OP_INVAL)) begin
         res = {1'b0, MSI_I};
      end
      return res;
   endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin arbiter: the first valid requester at or after ptr wins.
// The pointer register is owned by the caller; next_ptr is the slot after the winner.
module arbitro_rr #(
   parameter int N_CPU = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_CPU-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_CPU-1:0] grant_oh,
   output logic [IDX_W-1:0] grant_idx,
   output logic [IDX_W-1:0] next_ptr,
   output logic             any_valid
);

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int k = 0; k < N_CPU; k++) begin
         if (!any_valid && valid[(int'(ptr) + k) % N_CPU]) begin
            any_valid = 1'b1;
            grant_idx = IDX_W'((int'(ptr) + k) % N_CPU);
         end
      end
      if (any_valid) begin
         grant_oh[grant_idx] = 1'b1;
      end
      next_ptr = (int'(grant_idx) == N_CPU - 1) ? '0 : grant_idx + IDX_W'(1);
   end

endmodule

// File: rtl/barramento_snoop.sv
// Shared-bus sequencer: arbitrates cache requests, runs writeback/snoop/flush/memory phases, acks requester.
// Define FLUSH_BYPASS_EN to let flushed data satisfy the requester and skip the memory read after FLUSH.
module barramento_snoop
   import barramento_pkg::*;
#(
   parameter int N_CPU      = 2,
   parameter int ADDR_W     = 4,
   parameter int WB_CYCLES  = 2,
   parameter int MEM_CYCLES = 3
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic [N_CPU-1:0]        req_valid,
   input  logic [2*N_CPU-1:0]      req_bus,
   input  logic [N_CPU-1:0]        req_wb,
   input  logic [N_CPU*ADDR_W-1:0] req_addr,
   output logic [N_CPU-1:0]        req_ready,
   input  logic [2*N_CPU-1:0]      remote_state,
   output logic                    snoop_valid,
   output logic [1:0]              snoop_op,
   output logic [ADDR_W-1:0]       snoop_addr,
   output logic [N_CPU-1:0]        remote_we,
   output logic [2*N_CPU-1:0]      remote_next,
   output logic                    mem_wr,
   output logic                    mem_rd
);

   localparam int IDX_W   = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   localparam int MAX_CYC = (WB_CYCLES > MEM_CYCLES) ? WB_CYCLES : MEM_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] WB_LOAD  = CNT_W'(WB_CYCLES - 1);
   localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [N_CPU-1:0]  arb_oh;
   logic [IDX_W-1:0]  arb_idx;
   logic [IDX_W-1:0]  arb_next;
   logic              arb_any;
   logic [1:0]        bus_arr  [N_CPU];
   logic [ADDR_W-1:0] addr_arr [N_CPU];
   logic [N_CPU-1:0]  flush_vec;
   logic              snoop_active;
   logic              any_flush;

   arbitro_rr #(
      .N_CPU (N_CPU),
      .IDX_W (IDX_W)
   ) u_arb (
      .valid     (req_valid),
      .ptr       (ptr_q),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx),
      .next_ptr  (arb_next),
      .any_valid (arb_any)
   );

   assign snoop_active = (state_q == ST_SNOOP);

   generate
      for (genvar gi = 0; gi < N_CPU; gi++) begin : g_cpu
         logic       peer;
         logic [2:0] rule;
         assign bus_arr[gi]  = req_bus[2*gi +: 2];
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         // The requester never snoops its own broadcast.
         assign peer = snoop_active && (grant_q != IDX_W'(gi));
         assign rule = snoop_rule(remote_state[2*gi +: 2], op_q);
         assign remote_next[2*gi +: 2] = peer ? rule[1:0] : 2'b00;
         assign remote_we[gi]  = peer && (rule[1:0] != remote_state[2*gi +: 2]);
         assign flush_vec[gi]  = peer && rule[2];
         assign req_ready[gi]  = (state_q == ST_DONE) && (grant_q == IDX_W'(gi));
      end
   endgenerate

   assign any_flush   = |flush_vec;
   assign snoop_valid = snoop_active;
   assign snoop_op    = snoop_active ? op_q : 2'b00;
   assign snoop_addr  = snoop_active ? addr_q : '0;
   assign mem_wr      = (state_q == ST_WB) || (state_q == ST_FLUSH);
   assign mem_rd      = (state_q == ST_MEM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      op_d    = op_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (arb_any) begin
               grant_d = arb_idx;
               ptr_d   = arb_next;
               op_d    = bus_arr[arb_idx];
               addr_d  = addr_arr[arb_idx];
               if (bus_arr[arb_idx] == OP_NONE) begin
                  state_d = ST_DONE;
               end else if (|(req_wb & arb_oh)) begin
                  state_d = ST_WB;
                  cnt_d   = WB_LOAD;
               end else begin
                  state_d = ST_SNOOP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WB: begin
            if (cnt_q == '0) state_d = ST_SNOOP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_SNOOP: begin
            if (op_q == OP_INVAL) begin
               state_d = ST_DONE;
            end else if (any_flush) begin
               state_d = ST_FLUSH;
               cnt_d   = WB_LOAD;
            end else begin
               state_d = ST_MEM;
               cnt_d   = MEM_LOAD;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
`ifdef FLUSH_BYPASS_EN
               state_d = ST_DONE;
`else
               state_d = ST_MEM;
               cnt_d   = MEM_LOAD;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_MEM: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         op_q    <= 2'b00;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_barramento_snoop.sv
// Testbench for barramento_snoop: directed vector table, randomized transactions against a
// transaction-level model, and reset-abort plus round-robin fairness sequences.
module tb_barramento_snoop;

   localparam int N_CPU      = 2;
   localparam int ADDR_W     = 4;
   localparam int WB_CYCLES  = 2;
   localparam int MEM_CYCLES = 3;
`ifdef FLUSH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                    Clock;
   logic                    Reset_n;
   logic [N_CPU-1:0]        req_valid;
   logic [2*N_CPU-1:0]      req_bus;
   logic [N_CPU-1:0]        req_wb;
   logic [N_CPU*ADDR_W-1:0] req_addr;
   logic [N_CPU-1:0]        req_ready;
   logic [2*N_CPU-1:0]      remote_state;
   logic                    snoop_valid;
   logic [1:0]              snoop_op;
   logic [ADDR_W-1:0]       snoop_addr;
   logic [N_CPU-1:0]        remote_we;
   logic [2*N_CPU-1:0]      remote_next;
   logic                    mem_wr;
   logic                    mem_rd;
   logic [31:0]             all_outs;

   int n_checks = 0;
   int n_pass   = 0;
   int model_ptr = 0;

   typedef struct {
      logic [N_CPU-1:0]   req_mask;
      int                 cpu;
      logic [1:0]         op;
      logic               wb;
      logic [ADDR_W-1:0]  addr;
      logic [2*N_CPU-1:0] rs;
      int                 lat;
      int                 wr;
      int                 rd;
      int                 sn;
      logic [N_CPU-1:0]   we;
      logic [2*N_CPU-1:0] nxt;
   } vec_t;

   vec_t tbl [7];

   barramento_snoop #(
      .N_CPU      (N_CPU),
      .ADDR_W     (ADDR_W),
      .WB_CYCLES  (WB_CYCLES),
      .MEM_CYCLES (MEM_CYCLES)
   ) dut (
      .Clock        (Clock),
      .Reset_n      (Reset_n),
      .req_valid    (req_valid),
      .req_bus      (req_bus),
      .req_wb       (req_wb),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .remote_state (remote_state),
      .snoop_valid  (snoop_valid),
      .snoop_op     (snoop_op),
      .snoop_addr   (snoop_addr),
      .remote_we    (remote_we),
      .remote_next  (remote_next),
      .mem_wr       (mem_wr),
      .mem_rd       (mem_rd)
   );

   assign all_outs = 32'({req_ready, snoop_valid, snoop_op, snoop_addr,
                          remote_we, remote_next, mem_wr, mem_rd});

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input int cpu, input logic [1:0] op, input logic wb,
                               input logic [ADDR_W-1:0] addr, input logic [2*N_CPU-1:0] rs,
                               input int lat, input int wr, input int rd, input int sn,
                               input logic [N_CPU-1:0] we, input logic [2*N_CPU-1:0] nxt);
      vec_t v;
      v.req_mask = N_CPU'(1) << cpu;
      v.cpu = cpu; v.op = op; v.wb = wb; v.addr = addr; v.rs = rs;
      v.lat = lat; v.wr = wr; v.rd = rd; v.sn = sn; v.we = we; v.nxt = nxt;
      return v;
   endfunction

   // Snoop reaction of a peer cache, taken from the MSI rules.
   function automatic logic [1:0] peer_next(input logic [1:0] st, input logic [1:0] op);
      if (st == 2'b10 && op == 2'b01) return 2'b01;
      if (st != 2'b00 && op == 2'b10) return 2'b00;
      if (st == 2'b01 && op == 2'b11) return 2'b00;
      return st;
   endfunction

   function automatic bit peer_flush(input logic [1:0] st, input logic [1:0] op);
      return (st == 2'b10) && (op == 2'b01 || op == 2'b10);
   endfunction

   // Transaction-level expectation: who wins, which phases run and for how long.
   function automatic vec_t model_txn(input vec_t v, input int ptr);
      vec_t r;
      bit   flush;
      r = v;
      flush = 1'b0;
      r.cpu = -1;
      for (int k = 0; k < N_CPU; k++)
         if (r.cpu < 0 && v.req_mask[(ptr + k) % N_CPU]) r.cpu = (ptr + k) % N_CPU;
      r.we = '0; r.nxt = '0; r.sn = 0; r.wr = 0; r.rd = 0;
      if (v.op == 2'b00) begin
         r.lat = 2;
      end else begin
         r.sn = 1;
         for (int i = 0; i < N_CPU; i++) begin
            if (i != r.cpu) begin
               r.nxt[2*i +: 2] = peer_next(v.rs[2*i +: 2], v.op);
               r.we[i] = (r.nxt[2*i +: 2] != v.rs[2*i +: 2]);
               if (peer_flush(v.rs[2*i +: 2], v.op)) flush = 1'b1;
            end
         end
         r.wr  = (v.wb ? WB_CYCLES : 0) + (flush ? WB_CYCLES : 0);
         r.rd  = (v.op == 2'b11 || (flush && BYPASS)) ? 0 : MEM_CYCLES;
         r.lat = 3 + r.wr + r.rd;
      end
      return r;
   endfunction

   // Runs one transaction starting just after a rising edge with the bus idle.
   task automatic run_txn(input vec_t v, input string tag);
      bit got;
      int lat, sn, wr, rd;
      logic [N_CPU-1:0]   we_s, rdy;
      logic [2*N_CPU-1:0] nx_s;
      logic [1:0]         op_s;
      logic [ADDR_W-1:0]  ad_s;
      got = 1'b0; lat = -1; sn = 0; wr = 0; rd = 0;
      we_s = '0; rdy = '0; nx_s = '0; op_s = '0; ad_s = '0;
      req_valid = '0; req_wb = '0; req_bus = '0; req_addr = '0;
      for (int i = 0; i < N_CPU; i++) begin
         if (v.req_mask[i]) begin
            req_valid[i] = 1'b1;
            req_bus[2*i +: 2] = 2'($urandom);
            req_wb[i] = 1'($urandom);
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
         end
      end
      req_bus[2*v.cpu +: 2] = v.op;
      req_wb[v.cpu] = v.wb;
      req_addr[v.cpu*ADDR_W +: ADDR_W] = v.addr;
      remote_state = v.rs;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge Clock);
         if (snoop_valid) begin
            sn++; we_s = remote_we; nx_s = remote_next; op_s = snoop_op; ad_s = snoop_addr;
         end
         if (mem_wr) wr++;
         if (mem_rd) rd++;
         if (req_ready != '0) begin
            got = 1'b1; lat = c; rdy = req_ready;
         end
         @(posedge Clock);
         #1;
         if (got) begin
            req_valid = '0;
         end else if (c >= 1) begin
            for (int i = 0; i < N_CPU; i++) begin
               if (i != v.cpu) begin
                  req_valid[i] = 1'($urandom);
                  req_bus[2*i +: 2] = 2'($urandom);
                  req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
               end
            end
         end
      end
      check({tag, " ack_seen"}, 32'(got), 32'(1));
      check({tag, " latency"}, lat, v.lat);
      check({tag, " ready_vec"}, 32'(rdy), 32'(1) << v.cpu);
      check({tag, " snoop_cnt"}, sn, v.sn);
      check({tag, " mem_wr_cycles"}, wr, v.wr);
      check({tag, " mem_rd_cycles"}, rd, v.rd);
      if (v.sn != 0) begin
         check({tag, " remote_we"}, 32'(we_s), 32'(v.we));
         check({tag, " remote_next"}, 32'(nx_s), 32'(v.nxt));
         check({tag, " snoop_op"}, 32'(op_s), 32'(v.op));
         check({tag, " snoop_addr"}, 32'(ad_s), 32'(v.addr));
      end
      $display("%s: cpu%0d op=%0d wb=%0d rs=%b -> ack@%0d wr=%0d rd=%0d we=%b next=%b",
               tag, v.cpu, v.op, v.wb, v.rs, lat, wr, rd, we_s, nx_s);
   endtask

   initial begin
      bit seen, early_ack;
      int nacks;
      logic [N_CPU-1:0] order [4];

      // rs / nxt layout: {cpu1, cpu0}, MSI codes I=00 S=01 M=10
      tbl[0] = mk(0, 2'b01, 1'b0, 4'h3, 4'b00_00, 6, 0, 3, 1, 2'b00, 4'b00_00);
      tbl[1] = mk(1, 2'b10, 1'b1, 4'hA, 4'b00_01, 8, 2, 3, 1, 2'b01, 4'b00_00);
      tbl[2] = mk(0, 2'b01, 1'b0, 4'h7, 4'b10_00, BYPASS ? 5 : 8, 2, BYPASS ? 0 : 3, 1,
                  2'b10, 4'b01_00);
      tbl[3] = mk(0, 2'b11, 1'b0, 4'hC, 4'b01_00, 3, 0, 0, 1, 2'b10, 4'b00_00);
      tbl[4] = mk(1, 2'b00, 1'b0, 4'h1, 4'b01_01, 2, 0, 0, 0, 2'b00, 4'b00_00);
      tbl[5] = mk(0, 2'b10, 1'b1, 4'hF, 4'b10_00, BYPASS ? 7 : 10, 4, BYPASS ? 0 : 3, 1,
                  2'b10, 4'b00_00);
      tbl[6] = mk(1, 2'b01, 1'b0, 4'h9, 4'b00_01, 6, 0, 3, 1, 2'b00, 4'b00_01);

      Reset_n = 1'b0;
      req_valid = '0; req_bus = '0; req_wb = '0; req_addr = '0; remote_state = '0;
      repeat (3) @(negedge Clock);
      check("reset outputs", all_outs, 32'd0);
      $display("reset: outputs=0x%0h", all_outs);
      Reset_n = 1'b1;
      @(posedge Clock);
      #1;

      for (int k = 0; k < 7; k++) begin
         run_txn(tbl[k], $sformatf("vec%0d", k));
         model_ptr = (tbl[k].cpu + 1) % N_CPU;
      end

      for (int n = 0; n < 40; n++) begin
         vec_t v;
         int   m_owner;
         v = tbl[0];
         v.req_mask = N_CPU'($urandom_range(1, (1 << N_CPU) - 1));
         v.op   = 2'($urandom);
         v.wb   = 1'($urandom);
         v.addr = ADDR_W'($urandom);
         m_owner = int'($urandom_range(0, N_CPU));
         for (int i = 0; i < N_CPU; i++)
            v.rs[2*i +: 2] = (i == m_owner) ? 2'b10 : (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00);
         v = model_txn(v, model_ptr);
         run_txn(v, $sformatf("rnd%0d", n));
         model_ptr = (v.cpu + 1) % N_CPU;
      end

      // Reset while in MEM: abort without ack, then fairness restarts at CPU0.
      req_valid = 2'b01; req_bus = 4'b00_01; req_wb = '0; req_addr = 8'h05; remote_state = '0;
      seen = 1'b0; early_ack = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge Clock);
         if (req_ready != '0) early_ack = 1'b1;
         if (mem_rd) seen = 1'b1;
      end
      check("abort reached_mem", 32'(seen), 32'(1));
      Reset_n = 1'b0;
      #1;
      check("abort outputs_cleared", all_outs, 32'd0);
      req_valid = 2'b11; req_bus = 4'b01_01;
      repeat (2) begin
         @(negedge Clock);
         if (req_ready != '0) early_ack = 1'b1;
      end
      check("abort held_outputs", all_outs, 32'd0);
      check("abort no_ack", 32'(early_ack), 32'(0));
      $display("abort: reset during MEM, early_ack=%0d", early_ack);
      Reset_n = 1'b1;

      nacks = 0;
      for (int k = 0; k < 4; k++) order[k] = '0;
      for (int c = 0; c < 80 && nacks < 4; c++) begin
         @(negedge Clock);
         if (req_ready != '0) begin
            order[nacks] = req_ready;
            nacks++;
         end
      end
      check("fair ack_count", nacks, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fair grant%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
         $display("fair: ack %0d -> ready=%b", k, order[k]);
      end
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
